// File: rtl/pay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pay_pkg
// Purpose  : Shared definitions for the payment collector. These include the
//            session state encoding, the coin face values, the BCD ceiling,
//            the default session length, and the BCD/binary helper functions.
// Revision : 1.0  initial release
// ============================================================================
package pay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PAID    = 2'd2,
        ST_EXPIRED = 2'd3
    } pay_state_t;

    // Coin face values 1, 5 and 10, held in two-digit BCD form so that they
    // can feed the BCD adder directly.
    localparam logic [7:0] c_COIN1_BCD  = 8'h01;
    localparam logic [7:0] c_COIN5_BCD  = 8'h05;
    localparam logic [7:0] c_COIN10_BCD = 8'h10;

    localparam int BCD_MAX               = 99;
    localparam int c_TIMEOUT_SEC_DEFAULT = 30;

    // Convert two packed BCD digits (00..99) to binary.
    function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
        return (7'(bcd[7:4]) * 7'd10) + 7'(bcd[3:0]);
    endfunction

    // Convert binary 0..99 to two packed BCD digits. Callers clamp first.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
        return {4'(bin / 7'd10), 4'(bin % 7'd10)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add2.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add2
// Purpose  : Two-digit BCD adder/subtractor. Addition saturates at 99 and
//            subtraction floors at 00, so the result is always valid BCD.
// Ports    : i_a, i_b  operands, 2 packed BCD digits each
//            i_sub     1 = i_a - i_b, 0 = i_a + i_b
//            o_y       result, 2 packed BCD digits
// Revision : 1.0  initial release
// ============================================================================
module bcd_add2
    import pay_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_sub,
    output logic [7:0] o_y
);

    // One spare bit of headroom holds sums up to 198 before the clamp.
    logic [7:0] w_a_bin;
    logic [7:0] w_b_bin;
    logic [7:0] w_res_bin;

    always_comb begin
        w_a_bin   = {1'b0, bcd_to_bin(i_a)};
        w_b_bin   = {1'b0, bcd_to_bin(i_b)};
        w_res_bin = w_a_bin + w_b_bin;
        if (i_sub) begin
            w_res_bin = (w_a_bin > w_b_bin) ? (w_a_bin - w_b_bin) : 8'd0;
        end else if (w_res_bin > 8'(BCD_MAX)) begin
            w_res_bin = 8'(BCD_MAX);
        end
        o_y = bin_to_bcd(w_res_bin[6:0]);
    end

endmodule
`default_nettype wire

// File: rtl/pay_collect.sv
`default_nettype none
// ============================================================================
// Module   : pay_collect
// Purpose  : Coin payment collector with a BCD countdown session timer.
//            EN opens a session and latches the price. Coins accumulate until
//            the price is covered (PAID) or the countdown reaches 00
//            (EXPIRED, which refunds everything inserted).
// Ports    : clk, rst (async, active-low)
//            EN                    session request
//            costone/costten       BCD price, latched at session start
//            coin1/coin5/coin10    single-cycle coin pulses
//            paidone/paidten       BCD amount inserted
//            changeone/changeten   BCD change (PAID) or refund (EXPIRED)
//            secone/secten         BCD seconds remaining
//            busy/done/timeout     collecting / paid in full / expired
// Config   : PAY_CHANGE_EN  defined -> change = paid - cost in PAID
//                           undefined -> change reads 00 in PAID
// Revision : 1.0  initial release
// ============================================================================
module pay_collect
    import pay_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int TIMEOUT_SEC   = c_TIMEOUT_SEC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic [3:0] costone,
    input  logic [3:0] costten,
    input  logic       coin1,
    input  logic       coin5,
    input  logic       coin10,
    output logic [3:0] paidone,
    output logic [3:0] paidten,
    output logic [3:0] changeone,
    output logic [3:0] changeten,
    output logic [3:0] secone,
    output logic [3:0] secten,
    output logic       busy,
    output logic       done,
    output logic       timeout
);

    localparam int               c_TICK_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [7:0]       c_SEC_INIT  = bin_to_bcd(7'(TIMEOUT_SEC));

    pay_state_t          r_state;
    pay_state_t          w_state_next;
    logic [7:0]          r_cost;
    logic [7:0]          r_paid;
    logic [7:0]          r_change;
    logic [7:0]          r_sec;
    logic [c_TICK_W-1:0] r_tick;

    logic [7:0] w_coin_val;
    logic [7:0] w_paid_sum;
    logic [7:0] w_sec_dec;
    logic [7:0] w_change_paid;
    logic       w_tick_wrap;
    logic       w_expire;
    logic       w_start;
    logic       w_run;

    // Simultaneous coins: only the highest value is accepted.
    always_comb begin
        w_coin_val = 8'h00;
        if (coin10) begin
            w_coin_val = c_COIN10_BCD;
        end else if (coin5) begin
            w_coin_val = c_COIN5_BCD;
        end else if (coin1) begin
            w_coin_val = c_COIN1_BCD;
        end
    end

    bcd_add2 u_paid_add (
        .i_a   (r_paid),
        .i_b   (w_coin_val),
        .i_sub (1'b0),
        .o_y   (w_paid_sum)
    );

    bcd_add2 u_sec_dec (
        .i_a   (r_sec),
        .i_b   (8'h01),
        .i_sub (1'b1),
        .o_y   (w_sec_dec)
    );

`ifdef PAY_CHANGE_EN
    logic [7:0] w_change_diff;

    // Change is based on the paid value that includes this cycle's coin,
    // so that it is already valid in the first PAID cycle.
    bcd_add2 u_change_sub (
        .i_a   (w_paid_sum),
        .i_b   (r_cost),
        .i_sub (1'b1),
        .o_y   (w_change_diff)
    );
    assign w_change_paid = w_change_diff;
`else
    assign w_change_paid = 8'h00;
`endif

    assign w_tick_wrap = (r_tick == c_TICK_LAST);
    // The last second runs out on the tick that would step sec from 01 to 00.
    assign w_expire    = w_tick_wrap && (r_sec == 8'h01);

    // Next-state logic. EN low overrides everything: the session closes and
    // the datapath holds, so coins in that cycle are not counted.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_run        = 1'b0;
        if (!EN) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_COLLECT;
                    w_start      = 1'b1;
                end
                ST_COLLECT: begin
                    w_run = 1'b1;
                    if (r_paid >= r_cost) begin
                        w_state_next = ST_PAID;
                    end else if (w_expire) begin
                        // A coin in the expiry cycle still counts. Payment
                        // that covers the price takes priority over expiry.
                        w_state_next = (w_paid_sum >= r_cost) ? ST_PAID : ST_EXPIRED;
                    end
                end
                ST_PAID, ST_EXPIRED: w_state_next = r_state;
                default:             w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cost   <= 8'h00;
            r_paid   <= 8'h00;
            r_change <= 8'h00;
            r_sec    <= 8'h00;
            r_tick   <= '0;
        end else if (w_start) begin
            r_cost   <= {costten, costone};
            r_paid   <= 8'h00;
            r_change <= 8'h00;
            r_sec    <= c_SEC_INIT;
            r_tick   <= '0;
        end else if (w_run) begin
            r_paid <= w_paid_sum;
            r_tick <= w_tick_wrap ? '0 : (r_tick + c_TICK_ONE);
            if (w_tick_wrap) begin
                r_sec <= w_sec_dec;
            end
            if (w_state_next == ST_PAID) begin
                r_change <= w_change_paid;
            end else if (w_state_next == ST_EXPIRED) begin
                r_change <= w_paid_sum;
            end
        end
    end

    assign {paidten, paidone}     = r_paid;
    assign {changeten, changeone} = r_change;
    assign {secten, secone}       = r_sec;
    assign busy    = (r_state == ST_COLLECT);
    assign done    = (r_state == ST_PAID);
    assign timeout = (r_state == ST_EXPIRED);

endmodule
`default_nettype wire

// File: tb/tb_pay_collect.sv
`default_nettype none
// ============================================================================
// Module   : tb_pay_collect
// Purpose  : Self-checking bench for pay_collect (TICKS_PER_SEC=10,
//            TIMEOUT_SEC=30). A session-level reference model runs alongside
//            the DUT and is compared every cycle. Directed scenarios pin
//            hand-computed values, and a randomized phase follows them.
// Revision : 1.0  initial release
// ============================================================================
module tb_pay_collect;

    localparam int c_TICKS   = 10;
    localparam int c_TIMEOUT = 30;
`ifdef PAY_CHANGE_EN
    localparam bit c_CHG = 1'b1;
`else
    localparam bit c_CHG = 1'b0;
`endif

    localparam int PH_IDLE    = 0;
    localparam int PH_COLLECT = 1;
    localparam int PH_PAID    = 2;
    localparam int PH_EXPIRED = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       EN = 1'b0;
    logic [3:0] costone = 4'd0;
    logic [3:0] costten = 4'd0;
    logic       coin1 = 1'b0;
    logic       coin5 = 1'b0;
    logic       coin10 = 1'b0;
    logic [3:0] paidone, paidten, changeone, changeten, secone, secten;
    logic       busy, done, timeout;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    pay_collect #(
        .TICKS_PER_SEC (c_TICKS),
        .TIMEOUT_SEC   (c_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .EN        (EN),
        .costone   (costone),
        .costten   (costten),
        .coin1     (coin1),
        .coin5     (coin5),
        .coin10    (coin10),
        .paidone   (paidone),
        .paidten   (paidten),
        .changeone (changeone),
        .changeten (changeten),
        .secone    (secone),
        .secten    (secten),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (session level, plain integers) -----
    typedef struct packed {
        int ph;
        int cost;
        int paid;
        int change;
        int sec;
        int elapsed;   // COLLECT cycles completed since entry
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t cur, input logic en,
                                          input logic [3:0] cten, input logic [3:0] cone,
                                          input logic c1, input logic c5, input logic c10);
        model_t nxt;
        int     coin;
        int     newpaid;
        bit     expiring;
        nxt = cur;
        if (!en) begin
            nxt.ph = PH_IDLE;
        end else if (cur.ph == PH_IDLE) begin
            nxt.ph      = PH_COLLECT;
            nxt.cost    = int'(cten) * 10 + int'(cone);
            nxt.paid    = 0;
            nxt.change  = 0;
            nxt.sec     = c_TIMEOUT;
            nxt.elapsed = 0;
        end else if (cur.ph == PH_COLLECT) begin
            coin        = c10 ? 10 : (c5 ? 5 : (c1 ? 1 : 0));
            newpaid     = (cur.paid + coin > 99) ? 99 : cur.paid + coin;
            expiring    = (cur.elapsed == c_TIMEOUT * c_TICKS - 1);
            nxt.paid    = newpaid;
            nxt.elapsed = cur.elapsed + 1;
            nxt.sec     = c_TIMEOUT - (cur.elapsed + 1) / c_TICKS;
            if (cur.paid >= cur.cost || (expiring && newpaid >= cur.cost)) begin
                nxt.ph     = PH_PAID;
                nxt.change = c_CHG ? (newpaid - cur.cost) : 0;
            end else if (expiring) begin
                nxt.ph     = PH_EXPIRED;
                nxt.change = newpaid;
            end
        end
        return nxt;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m <= '0;
        end else begin
            m <= model_step(m, EN, costten, costone, coin1, coin5, coin10);
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle comparison against the model -------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_paid",    32'({paidten, paidone}),     32'(to_bcd(m.paid)));
            check("model_change",  32'({changeten, changeone}), 32'(to_bcd(m.change)));
            check("model_sec",     32'({secten, secone}),       32'(to_bcd(m.sec)));
            check("model_busy",    32'(busy),    32'(m.ph == PH_COLLECT));
            check("model_done",    32'(done),    32'(m.ph == PH_PAID));
            check("model_timeout", 32'(timeout), 32'(m.ph == PH_EXPIRED));
        end
    end

    // ---------------- stimulus helpers ----------------------------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_coins(input bit c1, input bit c5, input bit c10);
        coin1  = c1;
        coin5  = c5;
        coin10 = c10;
    endtask

    // Returns while the DUT is in its first COLLECT cycle. The price inputs
    // are then scrambled so that any mid-session sampling would be exposed.
    task automatic open_session(input int cost);
        EN      = 1'b1;
        costten = 4'(cost / 10);
        costone = 4'(cost % 10);
        step();
        costten = 4'd9;
        costone = 4'd9;
    endtask

    task automatic close_session();
        set_coins(0, 0, 0);
        EN = 1'b0;
        step();
        step();
    endtask

    task automatic check_bcd(input string name, input logic [7:0] act, input logic [7:0] exp);
        check(name, 32'(act), 32'(exp));
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int density;
        #3 rst = 1'b0;
        step();
        cmp_en = 1'b1;
        check_bcd("reset_paid", {paidten, paidone}, 8'h00);
        check_bcd("reset_sec",  {secten, secone},   8'h00);
        check("reset_flags", 32'({busy, done, timeout}), 32'd0);
        rst = 1'b1;
        step();

        // Three coins reach the price of 25; done follows two cycles after the last coin.
        open_session(25);
        check("s25_busy", 32'(busy), 32'd1);
        check_bcd("s25_sec0", {secten, secone}, 8'h30);
        set_coins(0, 0, 1); step();
        check_bcd("s25_paid10", {paidten, paidone}, 8'h10);
        step();
        check_bcd("s25_paid20", {paidten, paidone}, 8'h20);
        set_coins(0, 1, 0); step();
        check_bcd("s25_paid25", {paidten, paidone}, 8'h25);
        check("s25_not_done_yet", 32'(done), 32'd0);
        set_coins(0, 0, 0); step();
        check("s25_done", 32'(done), 32'd1);
        check("s25_busy_off", 32'(busy), 32'd0);
        check_bcd("s25_change", {changeten, changeone}, 8'h00);
        close_session();
        check_bcd("idle_paid_retained", {paidten, paidone}, 8'h25);

        // Overpayment of 10 against a price of 07.
        open_session(7);
        set_coins(0, 0, 1); step();
        set_coins(0, 0, 0); step();
        check("s07_done", 32'(done), 32'd1);
        check_bcd("s07_change", {changeten, changeone}, c_CHG ? 8'h03 : 8'h00);
        close_session();

        // A price of 00 is covered one cycle after entry.
        open_session(0);
        step();
        check("s00_done", 32'(done), 32'd1);
        close_session();

        // A single coin5 against 50 expires exactly 300 cycles after entry.
        open_session(50);
        set_coins(0, 1, 0); step();
        set_coins(0, 0, 0);
        repeat (298) step();
        check("s50_busy_299", 32'(busy), 32'd1);
        check_bcd("s50_sec_299", {secten, secone}, 8'h01);
        step();
        check("s50_timeout", 32'(timeout), 32'd1);
        check_bcd("s50_refund", {changeten, changeone}, 8'h05);
        check_bcd("s50_sec_300", {secten, secone}, 8'h00);
        set_coins(0, 0, 1); step();
        check_bcd("s50_coin_ignored", {paidten, paidone}, 8'h05);
        close_session();

        // Three coins in one cycle are counted as a single coin10.
        open_session(40);
        set_coins(1, 1, 1); step();
        check_bcd("s40_priority", {paidten, paidone}, 8'h10);
        close_session();

        // Saturation at 99: 90 + 5 + 10 -> 99, and a further coin10 still leaves 99.
        open_session(99);
        set_coins(0, 0, 1);
        repeat (9) step();
        check_bcd("s99_paid90", {paidten, paidone}, 8'h90);
        set_coins(0, 1, 0); step();
        set_coins(0, 0, 1); step();
        check_bcd("s99_sat", {paidten, paidone}, 8'h99);
        step();
        check_bcd("s99_sat_hold", {paidten, paidone}, 8'h99);
        check("s99_done", 32'(done), 32'd1);
        close_session();

        // A coin arriving in the exact expiry cycle covers the price, so PAID wins.
        open_session(15);
        set_coins(0, 1, 0); step();
        set_coins(0, 0, 0);
        repeat (298) step();
        check_bcd("s15_paid05", {paidten, paidone}, 8'h05);
        set_coins(0, 0, 1); step();
        check("s15_done", 32'(done), 32'd1);
        check("s15_no_timeout", 32'(timeout), 32'd0);
        check_bcd("s15_paid15", {paidten, paidone}, 8'h15);
        close_session();

        // Reset in mid-session; with EN held high a new session starts after release.
        open_session(20);
        set_coins(0, 0, 1); step();
        set_coins(0, 0, 0);
        check_bcd("s20_paid10", {paidten, paidone}, 8'h10);
        rst = 1'b0;
        #1;
        check("s20_rst_flags", 32'({busy, done, timeout}), 32'd0);
        check_bcd("s20_rst_paid",   {paidten, paidone},     8'h00);
        check_bcd("s20_rst_change", {changeten, changeone}, 8'h00);
        check_bcd("s20_rst_sec",    {secten, secone},       8'h00);
        step();
        rst     = 1'b1;
        costten = 4'd2;
        costone = 4'd0;
        step();
        check("s20_restart_busy", 32'(busy), 32'd1);
        check_bcd("s20_restart_sec", {secten, secone}, 8'h30);
        close_session();

        // Randomized traffic: sessions of random length and coin density.
        density = 6;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 1999) == 0) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
            end
            if (EN) begin
                if ($urandom_range(0, 149) == 0) EN = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                EN = 1'b1;
                case ($urandom_range(0, 2))
                    0:       density = 0;
                    1:       density = 60;
                    default: density = 6;
                endcase
            end
            costten = 4'($urandom_range(0, 9));
            costone = 4'($urandom_range(0, 9));
            if (density > 0) begin
                coin1  = ($urandom_range(0, density - 1) == 0);
                coin5  = ($urandom_range(0, density - 1) == 0);
                coin10 = ($urandom_range(0, density - 1) == 0);
            end else begin
                set_coins(0, 0, 0);
            end
            step();
        end
        set_coins(0, 0, 0);
        step();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pay_collect.md
PAY_COLLECT -- requirements
Module: pay_collect

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000, clk cycles per countdown second.
REQ-002 SHALL have parameter TIMEOUT_SEC, default 30, session length in seconds, BCD-representable, 1..99.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 EN  input  1  session request; high = customer session open.
REQ-006 costone, costten  input  4 each  BCD price digits; sampled on session start only.
REQ-007 coin1, coin5, coin10  input  1 each  debounced single-cycle coin pulses, values 1/5/10.
REQ-008 paidone, paidten  output  4 each  BCD amount inserted so far.
REQ-009 changeone, changeten  output  4 each  BCD change or refund amount.
REQ-010 secone, secten  output  4 each  BCD seconds remaining.
REQ-011 busy, done, timeout  output  1 each  collecting, paid in full, session expired.

Function
REQ-012 SHALL implement states IDLE, COLLECT, PAID, EXPIRED.
REQ-013 IDLE: EN=1 -> COLLECT next cycle; latch cost; clear paid; load sec=TIMEOUT_SEC; clear tick counter.
REQ-014 COLLECT: busy=1; a coin pulse in cycle N SHALL update paid in cycle N+1.
REQ-015 Coins in the same cycle: accept only the highest value (coin10>coin5>coin1); drop the others.
REQ-016 Paid addition SHALL be two-digit BCD and saturate at 99; no wrap.
REQ-017 Registered paid >= latched cost -> PAID next cycle; cost 00 -> PAID one cycle after entering COLLECT.
REQ-018 Sec SHALL decrement every TICKS_PER_SEC cycles in COLLECT; the step to 00 SHALL enter EXPIRED. Timeout = exactly TIMEOUT_SEC*TICKS_PER_SEC cycles after COLLECT entry.
REQ-019 Paid>=cost and expiry in the same cycle: PAID wins.
REQ-020 Coin and expiry in the same cycle: coin counted; PAID if coin covers cost, else EXPIRED.
REQ-021 PAID: done=1, busy=0; coins ignored; sec frozen; hold until EN=0.
REQ-022 EXPIRED: timeout=1, change=paid (full refund); coins ignored; hold until EN=0.
REQ-023 EN=0 in any state -> IDLE next cycle; paid/change retain last values until the next session start.
REQ-024 Cost inputs changing mid-session SHALL have no effect.

Reset
REQ-025 rst low SHALL asynchronously force IDLE; clear paid, change, tick counter; set sec=00; busy/done/timeout=0.
REQ-026 Reset mid-session SHALL abandon the session with no refund output; the session restarts only on EN=1 after reset release.

Configuration
REQ-027 Macro PAY_CHANGE_EN defined: in PAID, change=paid-cost as BCD, valid in the same cycle done rises.
REQ-028 Macro PAY_CHANGE_EN undefined: change reads 00 in PAID; EXPIRED refund per REQ-022 is unaffected.

Structure
REQ-029 Shared package pay_pkg SHALL hold the state encoding, coin values (1, 5, 10), BCD_MAX=99, and the TIMEOUT_SEC default.
REQ-030 Sub-module bcd_add2 SHALL perform two-digit BCD add/subtract with saturation; use it for paid and change.

Verification (TICKS_PER_SEC=10, TIMEOUT_SEC=30)
REQ-031 Cost 25; coin10, coin10, coin5 -> paid 10, 20, 25; done=1 two cycles after the last coin; change 00.
REQ-032 Cost 07; coin10 -> done=1, change 03 with PAY_CHANGE_EN, 00 without.
REQ-033 Cost 50; coin5 only, no further coins -> EXPIRED at cycle 300 after COLLECT entry; timeout=1, change 05, sec 00.
REQ-034 Cost 40; coin1, coin5, coin10 in one cycle -> paid 10 only; coins to 99 then coin10 -> paid stays 99.
REQ-035 Cost 15, paid 05; coin10 in the exact expiry cycle -> done=1, timeout=0.
REQ-036 Cost 20; rst low mid-COLLECT with paid 10 -> immediate IDLE, all outputs 0; EN held high restarts a session after rst release.
